mmio_console_dev: RTL and testbench
===================================

Name: mmio_console_dev

Overview:
- Memory-mapped console/halt responder at the far end of the data-side memory_io protocol.
- Decodes core data requests in a 16-byte window and returns a memory_io_rsp for each.
- Buffers bytes written to TXDATA in a FIFO and drains them over a paced valid/ready byte stream.
- Asserts halt only after a halt request has been made and every buffered byte has drained.

Parameters:
- BASE_ADDR, 32'h0002_FFF0, window base; must be 16-byte aligned.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..128.
- DRAIN_DIV, 4, minimum cycles between successive tx handshakes; must be >= 1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req  input  memory_io_req  request from initiator (valid, addr, do_read, do_write, data, user_tag)
- rsp  output  memory_io_rsp  response (valid, addr, data, user_tag)
- tx_valid  output  1  byte available on tx_data
- tx_data  output  8  byte being sent
- tx_ready  input  1  sink accepts byte; handshake when tx_valid && tx_ready
- halt  output  1  sticky; program finished and console drained

Behaviour:
- Reset (async, active-high): rsp = memory_io_no_rsp, tx_valid = 0, tx_data = 0, halt = 0, FIFO empty, pacing counter = 0, overflow = 0, halt_req = 0, TXCNT = 0.
- Decode: a request hits when req.valid && req.addr[31:4] == BASE_ADDR[31:4]. Misses are ignored: no response and no state change.
- One request is accepted per cycle, with no backpressure.
- Response: registered, exactly 1 cycle after a hit. rsp.addr and rsp.user_tag echo the request. rsp.data is the register value sampled before that cycle's write; writes-only return 0.
- Register map (byte offset):
  - 0x0 STATUS, RO: [7:0] FIFO count, [8] full, [9] empty, [10] halt_req, [11] overflow (sticky; cleared only by reset). Other bits 0.
  - 0x4 TXCNT, RO: 16-bit count of bytes pushed, zero-extended; wraps 0xFFFF -> 0.
  - 0x8 TXDATA, WO: a write with do_write[0] set pushes data[7:0]. If the FIFO is full, the byte is dropped, overflow is set, and TXCNT is not incremented. Reads return 0.
  - 0xC HALT, W/R: a write with any do_write bit set sets halt_req (sticky). Reads return {31'b0, halt_req}.
- Writes to RO registers are ignored but still answered with a response.
- FIFO:
  - Simultaneous push and pop while full: both succeed and count is unchanged; no overflow.
  - Push while empty: tx_valid rises the cycle after the push, i.e. first-word latency 1, subject to pacing.
- TX pacing:
  - After each handshake, the pacing counter loads DRAIN_DIV-1.
  - tx_valid is held 0 while the counter is nonzero; the counter decrements each cycle.
  - With DRAIN_DIV = 1 there is back-to-back streaming.
  - tx_data is stable while tx_valid && !tx_ready.
- Halt: registered. Rises the cycle after halt_req && FIFO empty && !tx_valid all hold; it never falls until reset.
- Bytes pushed after halt_req is set are still buffered and drained. If halt is already high, such bytes are still accepted and sent.
- Reset mid-drain or mid-response: the in-flight response is dropped and queued bytes are discarded.

Optional Feature:
- Macro: CONSOLE_TRACE_EN.
- Defined: simulation-only $write of each tx_data byte (as a %c character) on handshake, and a $display line with the total TXCNT when halt rises.
- Undefined: no simulation output; RTL behaviour is otherwise identical.

Test Plan:
- Write 0x48 to 0x0002_FFF8 with user_tag 5, tx_ready = 1 -> rsp.valid next cycle with user_tag 5 and data 0; tx_valid = 1 with tx_data = 0x48 that same cycle.
- 17 writes to TXDATA with tx_ready = 0, then read 0x0002_FFF0 -> rsp.data = 0x0000_0910, and TXCNT (0x0002_FFF4) = 0x0000_0010.
- DRAIN_DIV = 4, tx_ready = 1, push bytes 0x41, 0x42, 0x43 -> handshakes at cycles t, t+4, t+8 in that order.
- Push 3 bytes, write 1 to 0x0002_FFFC with tx_ready = 0, then release tx_ready -> halt stays 0 until the cycle after the third handshake, then stays 1. A HALT read returns 0x1.
- Assert reset with 5 bytes queued -> tx_valid = 0 and halt = 0 immediately; after reset, a STATUS read returns 0x0000_0200.
- Request to 0x0001_0000, or to 0x0002_FFE8 -> no rsp.valid and no FIFO change; STATUS is unchanged.

Source files
------------

// File: rtl/memory_io_pkg.sv
// Request/response types shared by the data-side memory_io protocol.
package memory_io_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic [31:0] data;
    logic [7:0]  user_tag;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  user_tag;
  } memory_io_rsp;

  localparam memory_io_rsp memory_io_no_rsp = '0;

endpackage

// File: rtl/mmio_console_dev.sv
// Memory-mapped console/halt responder: TXDATA bytes go through a FIFO to a paced byte stream.
// Optional simulation trace of sent bytes and halt when CONSOLE_TRACE_EN is defined.
module mmio_console_dev
  import memory_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_FFF0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DRAIN_DIV  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req req,
  output memory_io_rsp rsp,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready,
  output logic         halt
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PACE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PACE_W-1:0] r_pace;
  logic             r_overflow;
  logic             r_halt_req;
  logic [15:0]      r_txcnt;
  logic             r_halt;
  memory_io_rsp     r_rsp;

  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_full;
  logic        w_empty;
  logic        w_tx_valid;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_halt_wr;
  logic        w_halt_set;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_hit      = req.valid && (req.addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = req.addr[3:2];
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_tx_valid = !w_empty && (r_pace == '0);
  assign w_pop      = w_tx_valid && tx_ready;
  assign w_push_req = w_hit && (w_off == 2'd2) && req.do_write[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_halt_wr  = w_hit && (w_off == 2'd3) && (|req.do_write);
  assign w_halt_set = r_halt_req && w_empty && !w_tx_valid && !r_halt;
  assign w_unused   = &{1'b0, req.addr[1:0], req.data[31:8]};

  assign w_status = {20'b0, r_overflow, r_halt_req, w_empty, w_full, 8'(r_count)};

  always_comb begin
    w_rdata = '0;
    case (w_off)
      2'd0:    w_rdata = w_status;
      2'd1:    w_rdata = {16'b0, r_txcnt};
      2'd3:    w_rdata = {31'b0, r_halt_req};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp <= memory_io_no_rsp;
    end else if (w_hit) begin
      r_rsp.valid    <= 1'b1;
      r_rsp.addr     <= req.addr;
      r_rsp.user_tag <= req.user_tag;
      r_rsp.data     <= (|req.do_read) ? w_rdata : '0;
    end else begin
      r_rsp <= memory_io_no_rsp;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= req.data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pace     <= '0;
      r_overflow <= 1'b0;
      r_halt_req <= 1'b0;
      r_txcnt    <= '0;
      r_halt     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_txcnt  <= r_txcnt + 16'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)             r_pace <= PACE_W'(DRAIN_DIV - 1);
      else if (r_pace != '0) r_pace <= r_pace - PACE_W'(1);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      if (w_halt_wr)             r_halt_req <= 1'b1;
      if (w_halt_set)            r_halt     <= 1'b1;
    end
  end

  assign rsp      = r_rsp;
  assign tx_valid = w_tx_valid;
  assign tx_data  = w_tx_valid ? r_mem[r_rd_ptr] : '0;
  assign halt     = r_halt;

`ifdef CONSOLE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_pop)      $write("%c", tx_data);
    if (!reset && w_halt_set) $display("console: halt, TXCNT=%0d", r_txcnt);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_mmio_console_dev.sv
// Directed and random checks of mmio_console_dev against a queue-based console model.
module tb_mmio_console_dev;
  import memory_io_pkg::*;

  localparam logic [31:0] BASE      = 32'h0002_FFF0;
  localparam int          DEPTH     = 16;
  localparam int          DRAIN_DIV = 4;

  logic         clk = 1'b0;
  logic         reset;
  memory_io_req req_i;
  memory_io_rsp rsp_o;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic         halt;

  always #5 clk = ~clk;

  mmio_console_dev #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DRAIN_DIV (DRAIN_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req_i),
    .rsp     (rsp_o),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .halt    (halt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural console model
  logic [7:0]  mq[$];
  int          m_txcnt;
  logic        m_ovf;
  logic        m_halt_req;
  logic        m_halt;
  int          m_last_hs;
  logic        m_rsp_v;
  logic [31:0] m_rsp_addr;
  logic [31:0] m_rsp_data;
  logic [7:0]  m_rsp_tag;

  typedef struct { int c; logic [7:0] d; } hs_t;
  hs_t  hs_log[$];
  logic halt_log[int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_txcnt    = 0;
    m_ovf      = 1'b0;
    m_halt_req = 1'b0;
    m_halt     = 1'b0;
    m_last_hs  = -1000;
    m_rsp_v    = 1'b0;
    m_rsp_addr = '0;
    m_rsp_data = '0;
    m_rsp_tag  = '0;
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] off);
    int n = mq.size();
    case (off)
      2'd0:    return {20'b0, m_ovf, m_halt_req, 1'(n == 0), 1'(n == DEPTH), 8'(n)};
      2'd1:    return 32'(m_txcnt % 65536);
      2'd3:    return {31'b0, m_halt_req};
      default: return 32'h0;
    endcase
  endfunction

  // Called at posedge+1: drive, check at negedge, advance model, return at next posedge+1.
  task automatic step(input logic v, input logic [31:0] a, input logic [3:0] rd_en,
                      input logic [3:0] wr_en, input logic [31:0] d, input logic [7:0] tag,
                      input logic rdy);
    int          n;
    logic        exp_tv, hs, hit;
    logic [1:0]  off;
    req_i.valid    = v;
    req_i.addr     = a;
    req_i.do_read  = rd_en;
    req_i.do_write = wr_en;
    req_i.data     = d;
    req_i.user_tag = tag;
    tx_ready       = rdy;
    @(negedge clk);
    n      = mq.size();
    exp_tv = (n != 0) && ((cyc - m_last_hs) >= DRAIN_DIV);
    chk("rsp_valid", 32'(rsp_o.valid), 32'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_addr", rsp_o.addr, m_rsp_addr);
      chk("rsp_tag", 32'(rsp_o.user_tag), 32'(m_rsp_tag));
      chk("rsp_data", rsp_o.data, m_rsp_data);
    end
    chk("tx_valid", 32'(tx_valid), 32'(exp_tv));
    if (exp_tv) chk("tx_data", 32'(tx_data), 32'(mq[0]));
    chk("halt", 32'(halt), 32'(m_halt));
    halt_log[cyc] = halt;
    if (tx_valid && tx_ready) hs_log.push_back('{cyc, tx_data});

    hit = v && (a[31:4] == BASE[31:4]);
    off = a[3:2];
    hs  = exp_tv && rdy;
    m_rsp_v    = hit;
    m_rsp_addr = hit ? a : 32'h0;
    m_rsp_tag  = hit ? tag : 8'h0;
    m_rsp_data = (hit && (rd_en != 4'h0)) ? m_reg(off) : 32'h0;
    if (m_halt_req && n == 0) m_halt = 1'b1;
    if (hs) begin
      void'(mq.pop_front());
      m_last_hs = cyc;
    end
    if (hit && off == 2'd2 && wr_en[0]) begin
      if (n < DEPTH || hs) begin
        mq.push_back(d[7:0]);
        m_txcnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (hit && off == 2'd3 && wr_en != 4'h0) m_halt_req = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    step(1'b1, a, 4'h0, 4'hF, d, 8'($urandom()), rdy);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy);
    step(1'b1, a, 4'hF, 4'h0, $urandom(), 8'($urandom()), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, $urandom(), 4'h0, 4'h0, $urandom(), 8'h0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_o.valid), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h;
    reset    = 1'b1;
    req_i    = '0;
    tx_ready = 1'b0;
    model_reset();
    #3;
    chk("init_rsp", 32'(rsp_o), 32'h0);
    chk("init_tx_valid", 32'(tx_valid), 32'h0);
    chk("init_tx_data", 32'(tx_data), 32'h0);
    chk("init_halt", 32'(halt), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First byte: response next cycle with tag echoed, byte visible the same cycle
    step(1'b1, 32'h0002_FFF8, 4'h0, 4'h1, 32'h48, 8'd5, 1'b1);
    chk("t1_rsp_valid", 32'(rsp_o.valid), 32'h1);
    chk("t1_rsp_tag", 32'(rsp_o.user_tag), 32'd5);
    chk("t1_rsp_data", rsp_o.data, 32'h0);
    chk("t1_tx_valid", 32'(tx_valid), 32'h1);
    chk("t1_tx_data", 32'(tx_data), 32'h48);
    idle(3, 1'b1);

    // Overflow: 17 writes into a stalled sink
    do_reset();
    for (int i = 0; i < 17; i++) wr(32'h0002_FFF8, $urandom(), 1'b0);
    rd(32'h0002_FFF0, 1'b0);
    chk("ovf_status", rsp_o.data, 32'h0000_0910);
    rd(32'h0002_FFF4, 1'b0);
    chk("ovf_txcnt", rsp_o.data, 32'h0000_0010);
    idle(1, 1'b0);

    // Reset with 5 queued, then misses leave state alone
    do_reset();
    for (int i = 0; i < 5; i++) wr(32'h0002_FFF8, $urandom(), 1'b0);
    do_reset();
    rd(32'h0002_FFF0, 1'b0);
    chk("post_rst_status", rsp_o.data, 32'h0000_0200);
    wr(32'h0001_0000, 32'h55, 1'b1);
    chk("miss1_rsp", 32'(rsp_o.valid), 32'h0);
    wr(32'h0002_FFE8, 32'h66, 1'b1);
    chk("miss2_rsp", 32'(rsp_o.valid), 32'h0);
    rd(32'h0002_FFF0, 1'b0);
    chk("miss_status", rsp_o.data, 32'h0000_0200);

    // Pacing: three bytes, handshakes DRAIN_DIV apart
    do_reset();
    hs_log.delete();
    wr(32'h0002_FFF8, 32'h41, 1'b1);
    wr(32'h0002_FFF8, 32'h42, 1'b1);
    wr(32'h0002_FFF8, 32'h43, 1'b1);
    idle(12, 1'b1);
    chk("pace_count", 32'(hs_log.size()), 32'd3);
    if (hs_log.size() >= 3) begin
      chk("pace_d0", 32'(hs_log[0].d), 32'h41);
      chk("pace_d1", 32'(hs_log[1].d), 32'h42);
      chk("pace_d2", 32'(hs_log[2].d), 32'h43);
      chk("pace_gap1", 32'(hs_log[1].c - hs_log[0].c), 32'(DRAIN_DIV));
      chk("pace_gap2", 32'(hs_log[2].c - hs_log[1].c), 32'(DRAIN_DIV));
    end

    // Halt waits for the drain, then sticks
    do_reset();
    hs_log.delete();
    for (int i = 0; i < 3; i++) wr(32'h0002_FFF8, 32'h61 + 32'(i), 1'b0);
    wr(32'h0002_FFFC, 32'h1, 1'b0);
    idle(3, 1'b0);
    idle(14, 1'b1);
    chk("halt_hs_count", 32'(hs_log.size()), 32'd3);
    if (hs_log.size() >= 3) begin
      h = hs_log[2].c;
      chk("halt_low_after_hs", 32'(halt_log.exists(h + 1) ? halt_log[h + 1] : 1'bx), 32'h0);
      chk("halt_rise", 32'(halt_log.exists(h + 2) ? halt_log[h + 2] : 1'bx), 32'h1);
    end
    rd(32'h0002_FFFC, 1'b1);
    chk("halt_read", rsp_o.data, 32'h1);
    wr(32'h0002_FFF8, 32'h7A, 1'b1);
    idle(3, 1'b1);
    chk("halt_sticky", 32'(halt), 32'h1);

    // Push and pop on the same cycle while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(32'h0002_FFF8, $urandom(), 1'b0);
    wr(32'h0002_FFF8, 32'hA5, 1'b1);
    rd(32'h0002_FFF0, 1'b0);
    chk("full_pushpop_status", rsp_o.data, 32'h0000_0110);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 99) < 85) ? (BASE | 32'($urandom_range(0, 15))) : $urandom();
      step(1'($urandom_range(0, 3) != 0), a, ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0,
           4'($urandom_range(0, 15)), $urandom(), 8'($urandom()),
           1'($urandom_range(0, 2) != 0));
    end
    idle(80, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
